// File: rtl/hpi_responder.sv
// CY7C67200 host-port interface responder: decodes HPI register accesses into a
// local word memory, a bidirectional mailbox and a status register.
module hpi_responder #(
  parameter int MEM_WORDS = 4096
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic        OTG_RST_N,
  input  logic [15:0] OTG_DATA_in,
  output logic [15:0] OTG_DATA_out,
  output logic        OTG_DATA_oe,
  output logic        OTG_INT,
  output logic [15:0] mbx_in_data,
  output logic        mbx_in_valid,
  input  logic        mbx_in_ack,
  input  logic [15:0] mbx_out_data,
  input  logic        mbx_out_post,
  output logic        mbx_out_ready
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_COMMIT,
    ST_RD_FETCH,
    ST_RD_DRIVE,
    ST_WAIT_REL
  } state_e;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_MAILBOX = 2'd1,
    REG_ADDRESS = 2'd2,
    REG_STATUS  = 2'd3
  } reg_e;

  // Registered copies of the host bus plus the previous strobe levels for edge detection.
  logic [1:0]  addr_in_q;
  logic [15:0] data_in_q;
  logic        cs_n_q;
  logic        rd_n_q;
  logic        wr_n_q;
  logic        otg_rst_n_q;
  logic        rd_n_prev_q;
  logic        wr_n_prev_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_in_q   <= 2'd0;
      data_in_q   <= 16'd0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      otg_rst_n_q <= 1'b1;
      rd_n_prev_q <= 1'b1;
      wr_n_prev_q <= 1'b1;
    end else begin
      addr_in_q   <= OTG_ADDR;
      data_in_q   <= OTG_DATA_in;
      cs_n_q      <= OTG_CS_N;
      rd_n_q      <= OTG_RD_N;
      wr_n_q      <= OTG_WR_N;
      otg_rst_n_q <= OTG_RST_N;
      rd_n_prev_q <= rd_n_q;
      wr_n_prev_q <= wr_n_q;
    end
  end

  state_e      state_q, state_d;
  reg_e        cmd_reg_q, cmd_reg_d;
  logic [15:0] cmd_data_q, cmd_data_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] mbx_in_q, mbx_in_d;
  logic        mbx_in_full_q, mbx_in_full_d;
  logic [15:0] mbx_out_q, mbx_out_d;
  logic        mbx_out_full_q, mbx_out_full_d;
  logic [15:0] dout_q, dout_d;
  logic        oe_q, oe_d;

  logic        wr_fall;
  logic        rd_fall;
  logic        start_wr;
  logic        start_rd;
  logic        post_ok;
  logic        mbx_out_clr;
  logic        mem_we;
  logic [15:0] mem_rdata_q;
  logic [15:0] mem [MEM_WORDS];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d        = state_q;
    cmd_reg_d      = cmd_reg_q;
    cmd_data_d     = cmd_data_q;
    addr_d         = addr_q;
    mbx_in_d       = mbx_in_q;
    mbx_in_full_d  = mbx_in_full_q;
    mbx_out_d      = mbx_out_q;
    mbx_out_full_d = mbx_out_full_q;
    dout_d         = dout_q;
    mbx_out_clr    = 1'b0;
    mem_we         = 1'b0;

    wr_fall  = wr_n_prev_q & ~wr_n_q;
    rd_fall  = rd_n_prev_q & ~rd_n_q;
    start_wr = ~cs_n_q & wr_fall;
    start_rd = ~cs_n_q & rd_fall & ~wr_fall;
    post_ok  = mbx_out_post & ~mbx_out_full_q;

    if (mbx_in_ack) mbx_in_full_d = 1'b0;
    if (post_ok)    mbx_out_d     = mbx_out_data;

    unique case (state_q)
      ST_IDLE: begin
        if (start_wr) begin
          state_d    = ST_WR_COMMIT;
          cmd_reg_d  = reg_e'(addr_in_q);
          cmd_data_d = data_in_q;
        end else if (start_rd) begin
          state_d    = ST_RD_FETCH;
          cmd_reg_d  = reg_e'(addr_in_q);
        end
      end
      ST_WR_COMMIT: begin
        state_d = ST_WAIT_REL;
        unique case (cmd_reg_q)
          REG_DATA: begin
            mem_we = 1'b1;
            addr_d = addr_q + 16'd2;
          end
          REG_MAILBOX: begin
            mbx_in_d      = cmd_data_q;
            mbx_in_full_d = 1'b1;
          end
          REG_ADDRESS: addr_d = cmd_data_q;
          REG_STATUS:  ;
        endcase
      end
      ST_RD_FETCH: begin
        state_d = ST_RD_DRIVE;
        unique case (cmd_reg_q)
          REG_DATA: begin
            dout_d = mem_rdata_q;
            addr_d = addr_q + 16'd2;
          end
          REG_MAILBOX: begin
            dout_d      = mbx_out_q;
            mbx_out_clr = 1'b1;
          end
          REG_ADDRESS: dout_d = addr_q;
          REG_STATUS:  dout_d = {14'd0, mbx_out_full_q, mbx_in_full_q};
        endcase
      end
      ST_RD_DRIVE: if (rd_n_q | cs_n_q) state_d = ST_IDLE;
      ST_WAIT_REL: if (wr_n_q | cs_n_q) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // A post accepted in the same cycle as the host's clearing read keeps the flag set.
    if (mbx_out_clr) mbx_out_full_d = 1'b0;
    if (post_ok)     mbx_out_full_d = 1'b1;

    oe_d = (state_d == ST_RD_DRIVE);

    if (!otg_rst_n_q) begin
      state_d        = ST_IDLE;
      addr_d         = 16'd0;
      mbx_in_d       = 16'd0;
      mbx_in_full_d  = 1'b0;
      mbx_out_d      = 16'd0;
      mbx_out_full_d = 1'b0;
      dout_d         = 16'd0;
      oe_d           = 1'b0;
      mem_we         = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= ST_IDLE;
      cmd_reg_q      <= REG_DATA;
      cmd_data_q     <= 16'd0;
      addr_q         <= 16'd0;
      mbx_in_q       <= 16'd0;
      mbx_in_full_q  <= 1'b0;
      mbx_out_q      <= 16'd0;
      mbx_out_full_q <= 1'b0;
      dout_q         <= 16'd0;
      oe_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_reg_q      <= cmd_reg_d;
      cmd_data_q     <= cmd_data_d;
      addr_q         <= addr_d;
      mbx_in_q       <= mbx_in_d;
      mbx_in_full_q  <= mbx_in_full_d;
      mbx_out_q      <= mbx_out_d;
      mbx_out_full_q <= mbx_out_full_d;
      dout_q         <= dout_d;
      oe_q           <= oe_d;
    end
  end

  // NOTE: the memory array has no reset so it maps onto block RAM; its contents survive both resets.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[addr_q[AW:1]] <= cmd_data_q;
    mem_rdata_q <= mem[addr_q[AW:1]];
  end

  assign OTG_DATA_out  = dout_q;
  assign OTG_DATA_oe   = oe_q;
  assign OTG_INT       = mbx_out_full_q;
  assign mbx_in_data   = mbx_in_q;
  assign mbx_in_valid  = mbx_in_full_q;
  assign mbx_out_ready = ~mbx_out_full_q;

endmodule

// File: tb/tb_hpi_responder.sv
// Self-checking bench for hpi_responder: transaction-level model of the HPI register
// file, directed scenarios with literal expectations, then randomized traffic.
module tb_hpi_responder;

  localparam int MEM_WORDS = 4096;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  OTG_ADDR;
  logic        OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N;
  logic [15:0] OTG_DATA_in;
  logic [15:0] OTG_DATA_out;
  logic        OTG_DATA_oe;
  logic        OTG_INT;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack;
  logic [15:0] mbx_out_data;
  logic        mbx_out_post;
  logic        mbx_out_ready;

  hpi_responder #(.MEM_WORDS(MEM_WORDS)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .OTG_ADDR     (OTG_ADDR),
    .OTG_CS_N     (OTG_CS_N),
    .OTG_RD_N     (OTG_RD_N),
    .OTG_WR_N     (OTG_WR_N),
    .OTG_RST_N    (OTG_RST_N),
    .OTG_DATA_in  (OTG_DATA_in),
    .OTG_DATA_out (OTG_DATA_out),
    .OTG_DATA_oe  (OTG_DATA_oe),
    .OTG_INT      (OTG_INT),
    .mbx_in_data  (mbx_in_data),
    .mbx_in_valid (mbx_in_valid),
    .mbx_in_ack   (mbx_in_ack),
    .mbx_out_data (mbx_out_data),
    .mbx_out_post (mbx_out_post),
    .mbx_out_ready(mbx_out_ready)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the register file as the host and local side see it.
  bit [15:0]   m_mem     [MEM_WORDS];
  bit          m_written [MEM_WORDS];
  logic [15:0] m_addr, m_in_data, m_out_data;
  bit          m_in_full, m_out_full;
  bit          exp_oe, exp_dchk, chk_en;
  logic [15:0] exp_dout;

  function automatic int widx(input logic [15:0] a);
    return int'(a[15:1]) % MEM_WORDS;
  endfunction

  task automatic model_reset();
    m_addr     = 16'd0;
    m_in_data  = 16'd0;
    m_out_data = 16'd0;
    m_in_full  = 1'b0;
    m_out_full = 1'b0;
    exp_oe     = 1'b0;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [15:0] d);
    case (a)
      2'd0: begin
        m_mem[widx(m_addr)]     = d;
        m_written[widx(m_addr)] = 1'b1;
        m_addr                  = m_addr + 16'd2;
      end
      2'd1: begin
        m_in_data = d;
        m_in_full = 1'b1;
      end
      2'd2: m_addr = d;
      default: ;
    endcase
  endtask

  task automatic model_read(input logic [1:0] a, input bit post_en, input logic [15:0] post_val);
    bit prev_full;
    prev_full = m_out_full;
    exp_dchk  = 1'b1;
    case (a)
      2'd0: begin
        exp_dchk = m_written[widx(m_addr)];
        exp_dout = m_mem[widx(m_addr)];
        m_addr   = m_addr + 16'd2;
      end
      2'd1: begin
        exp_dout   = m_out_data;
        m_out_full = 1'b0;
      end
      2'd2: exp_dout = m_addr;
      default: exp_dout = {14'd0, m_out_full, m_in_full};
    endcase
    if (post_en && !prev_full) begin
      m_out_data = post_val;
      m_out_full = 1'b1;
    end
    exp_oe = 1'b1;
  endtask

  // Compare process: every cycle, outputs against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("otg_int",       16'(OTG_INT),       16'(m_out_full));
      check("mbx_out_ready", 16'(mbx_out_ready), 16'(!m_out_full));
      check("mbx_in_valid",  16'(mbx_in_valid),  16'(m_in_full));
      check("mbx_in_data",   mbx_in_data,        m_in_data);
      check("data_oe",       16'(OTG_DATA_oe),   16'(exp_oe));
      if (exp_oe && exp_dchk) check("read_data", OTG_DATA_out, exp_dout);
    end
  end

  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    @(posedge Clk); #1;
    OTG_ADDR    = a;
    OTG_DATA_in = d;
    OTG_CS_N    = 1'b0;
    OTG_WR_N    = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    model_write(a, d);
    OTG_CS_N = 1'b1;
    OTG_WR_N = 1'b1;
    repeat (3) @(posedge Clk);
  endtask

  task automatic host_read(input logic [1:0] a, output logic [15:0] got,
                           input bit post_en, input logic [15:0] post_val);
    @(posedge Clk); #1;
    OTG_ADDR = a;
    OTG_CS_N = 1'b0;
    OTG_RD_N = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #1;
    if (post_en) begin
      mbx_out_post = 1'b1;
      mbx_out_data = post_val;
    end
    @(posedge Clk); #1;
    mbx_out_post = 1'b0;
    model_read(a, post_en, post_val);
    OTG_CS_N = 1'b1;
    OTG_RD_N = 1'b1;
    @(negedge Clk);
    got = OTG_DATA_out;
    @(posedge Clk);
    @(posedge Clk); #1;
    exp_oe = 1'b0;
    repeat (2) @(posedge Clk);
  endtask

  task automatic local_ack();
    @(posedge Clk); #1;
    mbx_in_ack = 1'b1;
    @(posedge Clk); #1;
    mbx_in_ack = 1'b0;
    m_in_full  = 1'b0;
  endtask

  task automatic local_post(input logic [15:0] v);
    @(posedge Clk); #1;
    mbx_out_post = 1'b1;
    mbx_out_data = v;
    @(posedge Clk); #1;
    mbx_out_post = 1'b0;
    if (!m_out_full) begin
      m_out_data = v;
      m_out_full = 1'b1;
    end
  endtask

  task automatic soft_reset();
    @(posedge Clk); #1;
    OTG_RST_N = 1'b0;
    @(posedge Clk); #1;
    OTG_RST_N = 1'b1;
    @(posedge Clk); #1;
    model_reset();
    repeat (2) @(posedge Clk);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] k;
    logic [15:0] base;
    k = 16'($urandom_range(0, 15)) << 1;
    case ($urandom_range(0, 2))
      0:       base = 16'h0100;
      1:       base = 16'h2100;
      default: base = 16'hFFF0;
    endcase
    return (base + k) | 16'($urandom_range(0, 1));
  endfunction

  logic [15:0] g;
  logic [15:0] v;
  int          op;

  initial begin
    OTG_ADDR     = 2'd0;
    OTG_CS_N     = 1'b1;
    OTG_RD_N     = 1'b1;
    OTG_WR_N     = 1'b1;
    OTG_RST_N    = 1'b1;
    OTG_DATA_in  = 16'd0;
    mbx_in_ack   = 1'b0;
    mbx_out_post = 1'b0;
    mbx_out_data = 16'd0;
    model_reset();
    exp_dout = 16'd0;
    exp_dchk = 1'b0;
    chk_en   = 1'b0;
    Reset    = 1'b1;
    #1 Reset = 1'b0;
    chk_en   = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_data_out",      OTG_DATA_out,        16'h0000);
    check("rst_oe",            16'(OTG_DATA_oe),    16'h0000);
    check("rst_int",           16'(OTG_INT),        16'h0000);
    check("rst_mbx_in_valid",  16'(mbx_in_valid),   16'h0000);
    check("rst_mbx_in_data",   mbx_in_data,         16'h0000);
    check("rst_mbx_out_ready", 16'(mbx_out_ready),  16'h0001);
    @(posedge Clk); #1 Reset = 1'b1;
    repeat (2) @(posedge Clk);

    // Memory write/read with auto-increment.
    host_write(2'd2, 16'h0100);
    host_write(2'd0, 16'hAAAA);
    host_write(2'd0, 16'h5555);
    host_write(2'd2, 16'h0100);
    host_read(2'd0, g, 1'b0, 16'h0); check("mem_rd0", g, 16'hAAAA);
    host_read(2'd0, g, 1'b0, 16'h0); check("mem_rd1", g, 16'h5555);
    host_read(2'd2, g, 1'b0, 16'h0); check("addr_after_rd", g, 16'h0104);

    // Host-to-local mailbox.
    host_write(2'd1, 16'h1234);
    @(negedge Clk);
    check("mbx_in_valid_set", 16'(mbx_in_valid), 16'h0001);
    check("mbx_in_data_val",  mbx_in_data,       16'h1234);
    host_read(2'd3, g, 1'b0, 16'h0); check("status_in_full", g, 16'h0001);
    local_ack();
    @(negedge Clk);
    check("mbx_in_valid_ack", 16'(mbx_in_valid), 16'h0000);

    // Local-to-host mailbox, including a rejected second post.
    local_post(16'hBEEF);
    @(negedge Clk);
    check("int_after_post",   16'(OTG_INT),       16'h0001);
    check("ready_after_post", 16'(mbx_out_ready), 16'h0000);
    local_post(16'h0000);
    host_read(2'd1, g, 1'b0, 16'h0); check("mbx_out_rd", g, 16'hBEEF);
    @(negedge Clk);
    check("int_after_rd", 16'(OTG_INT), 16'h0000);

    // Post lands in the same cycle as the clearing read.
    host_read(2'd1, g, 1'b1, 16'hCAFE); check("mbx_rd_race_old", g, 16'hBEEF);
    @(negedge Clk);
    check("int_race_kept", 16'(OTG_INT), 16'h0001);
    host_read(2'd1, g, 1'b0, 16'h0); check("mbx_rd_race_new", g, 16'hCAFE);

    // Address wrap and memory index aliasing.
    host_write(2'd2, 16'hFFFE);
    host_write(2'd0, 16'h7777);
    host_read(2'd2, g, 1'b0, 16'h0); check("addr_wrap", g, 16'h0000);
    host_write(2'd2, 16'h1FFE);
    host_read(2'd0, g, 1'b0, 16'h0); check("mem_wrap_word", g, 16'h7777);
    host_write(2'd2, 16'h2100);
    host_read(2'd0, g, 1'b0, 16'h0); check("mem_alias", g, 16'hAAAA);

    // Soft reset clears registers and flags but not memory.
    host_write(2'd1, 16'h4321);
    local_post(16'h1111);
    host_read(2'd3, g, 1'b0, 16'h0); check("status_both", g, 16'h0003);
    soft_reset();
    @(negedge Clk);
    check("srst_int",   16'(OTG_INT),      16'h0000);
    check("srst_valid", 16'(mbx_in_valid), 16'h0000);
    host_read(2'd2, g, 1'b0, 16'h0); check("srst_addr",   g, 16'h0000);
    host_read(2'd3, g, 1'b0, 16'h0); check("srst_status", g, 16'h0000);
    host_read(2'd1, g, 1'b0, 16'h0); check("srst_mbx_out", g, 16'h0000);
    host_write(2'd2, 16'h0102);
    host_read(2'd0, g, 1'b0, 16'h0); check("srst_mem_kept", g, 16'h5555);

    // Asynchronous reset in the middle of a read drive.
    @(posedge Clk); #1;
    OTG_ADDR = 2'd3;
    OTG_CS_N = 1'b0;
    OTG_RD_N = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    model_read(2'd3, 1'b0, 16'h0);
    #1 check("oe_before_areset", 16'(OTG_DATA_oe), 16'h0001);
    #1 Reset = 1'b0;
    model_reset();
    #1 check("oe_areset_drop", 16'(OTG_DATA_oe), 16'h0000);
    OTG_CS_N = 1'b1;
    OTG_RD_N = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (2) @(posedge Clk);
    host_write(2'd2, 16'h0100);
    host_read(2'd0, g, 1'b0, 16'h0); check("areset_mem_kept", g, 16'hAAAA);

    // Randomized traffic checked by the compare process against the model.
    for (int it = 0; it < 200; it++) begin
      op = int'($urandom_range(0, 9));
      v  = 16'($urandom);
      case (op)
        0:       host_write(2'd2, rand_addr());
        1, 2:    host_write(2'd0, v);
        3, 4:    host_read(2'd0, g, 1'b0, 16'h0);
        5:       host_write(2'd1, v);
        6:       host_read(2'd1, g, 1'($urandom_range(0, 1)), v);
        7:       begin
                   case ($urandom_range(0, 2))
                     0:       host_read(2'd3, g, 1'b0, 16'h0);
                     1:       host_read(2'd2, g, 1'b0, 16'h0);
                     default: host_write(2'd3, v);
                   endcase
                 end
        8:       local_ack();
        default: local_post(v);
      endcase
    end

    repeat (3) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
